// File: rtl/klp32_pkg.sv
// Shared types and encodings for the KLP32 multi-cycle control path.
package klp32_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } stateT;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_IALU    = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LUI     = 4'd5,
        CLS_AUIPC   = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JALR    = 4'd8,
        CLS_ILLEGAL = 4'd15
    } instClassT;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_PASSB = 4'b1011;

    // funct3[0] inverts the sense; funct3[2] selects less-than over equal.
    function automatic logic branchTaken(input logic [2:0] funct3,
                                         input logic brEq,
                                         input logic brLt);
        return funct3[0] ^ (funct3[2] ? brLt : brEq);
    endfunction

endpackage

// File: rtl/mc_controller_inst_decode.sv
// Combinational opcode classification for the multi-cycle controller.
module inst_decode
    import klp32_pkg::*;
(
    input  logic [6:0] opcode,
    output instClassT  instClass,
    output logic       legal
);

    always_comb begin
        instClass = CLS_ILLEGAL;
        case (opcode)
            OP_R:      instClass = CLS_R;
            OP_IALU:   instClass = CLS_IALU;
            OP_LOAD:   instClass = CLS_LOAD;
            OP_STORE:  instClass = CLS_STORE;
            OP_BRANCH: instClass = CLS_BRANCH;
            OP_LUI:    instClass = CLS_LUI;
            OP_AUIPC:  instClass = CLS_AUIPC;
            OP_JAL:    instClass = CLS_JAL;
            OP_JALR:   instClass = CLS_JALR;
            default:   instClass = CLS_ILLEGAL;
        endcase
        legal = (instClass != CLS_ILLEGAL);
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle KLP32 controller: FETCH/DECODE/EXEC/MEM/WB FSM with sticky TRAP.
module mc_controller
    import klp32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] inst,
    input  logic        BrEq,
    input  logic        BrLT,
    input  logic        mem_ready,
    output logic        PCWEn,
    output logic        PCSel,
    output logic        IRWEn,
    output logic        RegWEn,
    output logic        ALUsrc1,
    output logic        ALUsrc2,
    output logic        BrUn,
    output logic        mem_req,
    output logic        memRW,
    output logic        ldU,
    output logic [2:0]  immSel,
    output logic [3:0]  aluSel,
    output logic [1:0]  wb_select,
    output logic [2:0]  state,
    output logic        illegal
);

    stateT      stateReg;
    stateT      stateNext;
    logic [6:0] opcodeReg;
    logic [2:0] funct3Reg;
    logic       bit30Reg;
    instClassT  instClass;
    logic       legal;
    logic       taken;

    logic       aluSrc1D;
    logic       aluSrc2D;
    logic [2:0] immSelD;
    logic [3:0] aluSelD;

    // Only opcode, funct3 and inst[30] steer control; the rest belongs to the datapath.
    logic unusedInstBits;
    assign unusedInstBits = ^{inst[31], inst[29:15], inst[11:7]};

    inst_decode uDecode (
        .opcode    (opcodeReg),
        .instClass (instClass),
        .legal     (legal)
    );

    assign taken = branchTaken(funct3Reg, BrEq, BrLT);
    assign state = stateReg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateReg  <= FETCH;
            opcodeReg <= '0;
            funct3Reg <= '0;
            bit30Reg  <= '0;
        end else begin
            stateReg <= stateNext;
            if (stateReg == FETCH && run) begin
                opcodeReg <= inst[6:0];
                funct3Reg <= inst[14:12];
                bit30Reg  <= inst[30];
            end
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            FETCH:  stateNext = run ? DECODE : FETCH;
            DECODE: stateNext = legal ? EXEC : TRAP;
            EXEC: begin
                if (instClass == CLS_LOAD || instClass == CLS_STORE)
                    stateNext = MEM;
                else if (instClass == CLS_BRANCH)
                    stateNext = FETCH;
                else
                    stateNext = WB;
            end
            MEM: begin
                if (mem_ready)
                    stateNext = (instClass == CLS_LOAD) ? WB : FETCH;
            end
            WB:      stateNext = FETCH;
            TRAP:    stateNext = TRAP;
            default: stateNext = FETCH;
        endcase
    end

    always_comb begin
        aluSrc1D = 1'b0;
        aluSrc2D = 1'b0;
        immSelD  = IMM_I;
        aluSelD  = ALU_ADD;
        case (instClass)
            CLS_R: aluSelD = {bit30Reg, funct3Reg};
            CLS_IALU: begin
                aluSrc2D = 1'b1;
                aluSelD  = (funct3Reg == 3'b101) ? {bit30Reg, 3'b101} : {1'b0, funct3Reg};
            end
            CLS_LOAD:  aluSrc2D = 1'b1;
            CLS_STORE: begin
                aluSrc2D = 1'b1;
                immSelD  = IMM_S;
            end
            CLS_BRANCH: begin
                aluSrc1D = 1'b1;
                aluSrc2D = 1'b1;
                immSelD  = IMM_B;
            end
            CLS_LUI: begin
                aluSrc2D = 1'b1;
                immSelD  = IMM_U;
                aluSelD  = ALU_PASSB;
            end
            CLS_AUIPC: begin
                aluSrc1D = 1'b1;
                aluSrc2D = 1'b1;
                immSelD  = IMM_U;
            end
            CLS_JAL: begin
                aluSrc1D = 1'b1;
                aluSrc2D = 1'b1;
                immSelD  = IMM_J;
            end
            CLS_JALR: aluSrc2D = 1'b1;
            default: ;
        endcase
    end

    // ALU steering is held through MEM and WB so aluOut stays valid as address/result/jump target.
    always_comb begin
        PCWEn     = 1'b0;
        PCSel     = 1'b0;
        IRWEn     = 1'b0;
        RegWEn    = 1'b0;
        ALUsrc1   = 1'b0;
        ALUsrc2   = 1'b0;
        BrUn      = 1'b0;
        mem_req   = 1'b0;
        memRW     = 1'b0;
        ldU       = 1'b0;
        immSel    = '0;
        aluSel    = '0;
        wb_select = '0;
        illegal   = 1'b0;
        case (stateReg)
            FETCH: IRWEn = run;
            EXEC: begin
                ALUsrc1 = aluSrc1D;
                ALUsrc2 = aluSrc2D;
                immSel  = immSelD;
                aluSel  = aluSelD;
                if (instClass == CLS_BRANCH) begin
                    PCWEn = 1'b1;
                    PCSel = taken;
                    BrUn  = funct3Reg[1];
                end
            end
            MEM: begin
                ALUsrc1 = aluSrc1D;
                ALUsrc2 = aluSrc2D;
                immSel  = immSelD;
                aluSel  = aluSelD;
                mem_req = 1'b1;
                memRW   = (instClass == CLS_STORE);
                ldU     = (instClass == CLS_LOAD) && funct3Reg[2];
                PCWEn   = (instClass == CLS_STORE) && mem_ready;
            end
            WB: begin
                ALUsrc1 = aluSrc1D;
                ALUsrc2 = aluSrc2D;
                immSel  = immSelD;
                aluSel  = aluSelD;
                RegWEn  = 1'b1;
                PCWEn   = 1'b1;
                if (instClass == CLS_LOAD)
                    wb_select = WB_MEM;
                else if (instClass == CLS_JAL || instClass == CLS_JALR)
                    wb_select = WB_PC4;
                else
                    wb_select = WB_ALU;
                PCSel = (instClass == CLS_JAL || instClass == CLS_JALR);
            end
            TRAP: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] inst;
    logic        BrEq;
    logic        BrLT;
    logic        mem_ready;
    logic        PCWEn, PCSel, IRWEn, RegWEn, ALUsrc1, ALUsrc2, BrUn;
    logic        mem_req, memRW, ldU, illegal;
    logic [2:0]  immSel;
    logic [3:0]  aluSel;
    logic [1:0]  wb_select;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    logic [19:0] allOut;
    assign allOut = {PCWEn, PCSel, IRWEn, RegWEn, ALUsrc1, ALUsrc2, BrUn, mem_req,
                     memRW, ldU, immSel, aluSel, wb_select, illegal};

    always #5 clk = ~clk;

    mc_controller dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .inst      (inst),
        .BrEq      (BrEq),
        .BrLT      (BrLT),
        .mem_ready (mem_ready),
        .PCWEn     (PCWEn),
        .PCSel     (PCSel),
        .IRWEn     (IRWEn),
        .RegWEn    (RegWEn),
        .ALUsrc1   (ALUsrc1),
        .ALUsrc2   (ALUsrc2),
        .BrUn      (BrUn),
        .mem_req   (mem_req),
        .memRW     (memRW),
        .ldU       (ldU),
        .immSel    (immSel),
        .aluSel    (aluSel),
        .wb_select (wb_select),
        .state     (state),
        .illegal   (illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b0; inst = '0; BrEq = 1'b0; BrLT = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        #1;
        checks++; if (state !== S_FETCH) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state, S_FETCH); end
        checks++; if (allOut !== 20'h0) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", allOut, 20'h0); end
        run = 1'b1;
        tick();
        checks++; if (state !== S_FETCH) begin failures++; $display("FAIL reset_dominates_run got=%0d exp=%0d", state, S_FETCH); end
        reset = 1'b1; run = 1'b0;
        tick();
        checks++; if (state !== S_FETCH) begin failures++; $display("FAIL run0_hold got=%0d exp=%0d", state, S_FETCH); end
        checks++; if (IRWEn !== 1'b0) begin failures++; $display("FAIL run0_irwen got=%b exp=0", IRWEn); end
    endtask

    typedef struct {
        string       nm;
        logic [31:0] ins;
        logic [3:0]  alu;
        logic        s1;
        logic        s2;
        logic [2:0]  imm;
        logic [1:0]  wb;
        logic        pcs;
    } aluVecT;

    task automatic test_alu();
        aluVecT v[8];
        int cyc;
        v[0] = '{"add",   32'h002081B3, 4'b0000, 1'b0, 1'b0, 3'd0, 2'd1, 1'b0};
        v[1] = '{"sub",   32'h402081B3, 4'b1000, 1'b0, 1'b0, 3'd0, 2'd1, 1'b0};
        v[2] = '{"srai",  32'h4030D093, 4'b1101, 1'b0, 1'b1, 3'd0, 2'd1, 1'b0};
        v[3] = '{"addin", 32'hC0000093, 4'b0000, 1'b0, 1'b1, 3'd0, 2'd1, 1'b0};
        v[4] = '{"lui",   32'h123450B7, 4'b1011, 1'b0, 1'b1, 3'd3, 2'd1, 1'b0};
        v[5] = '{"auipc", 32'h00001097, 4'b0000, 1'b1, 1'b1, 3'd3, 2'd1, 1'b0};
        v[6] = '{"jal",   32'h008000EF, 4'b0000, 1'b1, 1'b1, 3'd4, 2'd2, 1'b1};
        v[7] = '{"jalr",  32'h000080E7, 4'b0000, 1'b0, 1'b1, 3'd0, 2'd2, 1'b1};
        for (int i = 0; i < 8; i++) begin
            inst = v[i].ins; run = 1'b1; mem_ready = 1'b1;
            #1;
            checks++; if (state !== S_FETCH || IRWEn !== 1'b1) begin failures++; $display("FAIL %s_fetch state=%0d irwen=%b exp state=0 irwen=1", v[i].nm, state, IRWEn); end
            cyc = 0;
            tick(); cyc++;
            checks++; if (state !== S_DECODE || allOut !== 20'h0) begin failures++; $display("FAIL %s_decode state=%0d out=%h exp state=1 out=0", v[i].nm, state, allOut); end
            tick(); cyc++;
            checks++; if (state !== S_EXEC) begin failures++; $display("FAIL %s_exec_state got=%0d exp=2", v[i].nm, state); end
            checks++; if ({aluSel, ALUsrc1, ALUsrc2, immSel} !== {v[i].alu, v[i].s1, v[i].s2, v[i].imm})
                begin failures++; $display("FAIL %s_exec_alu got alu=%b s1=%b s2=%b imm=%0d exp alu=%b s1=%b s2=%b imm=%0d", v[i].nm, aluSel, ALUsrc1, ALUsrc2, immSel, v[i].alu, v[i].s1, v[i].s2, v[i].imm); end
            checks++; if ({PCWEn, RegWEn, mem_req} !== 3'b000) begin failures++; $display("FAIL %s_exec_ctrl got pcwen=%b regwen=%b memreq=%b exp all 0", v[i].nm, PCWEn, RegWEn, mem_req); end
            tick(); cyc++;
            checks++; if (state !== S_WB || RegWEn !== 1'b1 || PCWEn !== 1'b1) begin failures++; $display("FAIL %s_wb state=%0d regwen=%b pcwen=%b exp state=4 regwen=1 pcwen=1", v[i].nm, state, RegWEn, PCWEn); end
            checks++; if ({wb_select, PCSel, aluSel, ALUsrc1, ALUsrc2} !== {v[i].wb, v[i].pcs, v[i].alu, v[i].s1, v[i].s2})
                begin failures++; $display("FAIL %s_wb_sel got wb=%0d pcsel=%b alu=%b s1=%b s2=%b exp wb=%0d pcsel=%b alu=%b s1=%b s2=%b", v[i].nm, wb_select, PCSel, aluSel, ALUsrc1, ALUsrc2, v[i].wb, v[i].pcs, v[i].alu, v[i].s1, v[i].s2); end
            tick(); cyc++;
            checks++; if (state !== S_FETCH || RegWEn !== 1'b0 || cyc != 4) begin failures++; $display("FAIL %s_return state=%0d regwen=%b cycles=%0d exp state=0 regwen=0 cycles=4", v[i].nm, state, RegWEn, cyc); end
        end
        mem_ready = 1'b0;
    endtask

    typedef struct {
        string       nm;
        logic [31:0] ins;
        logic        eq;
        logic        lt;
        logic        pcs;
        logic        un;
    } brVecT;

    task automatic test_branch();
        brVecT v[6];
        v[0] = '{"beq_t",  32'h00208463, 1'b1, 1'b0, 1'b1, 1'b0};
        v[1] = '{"beq_nt", 32'h00208463, 1'b0, 1'b1, 1'b0, 1'b0};
        v[2] = '{"bne_nt", 32'h00209463, 1'b1, 1'b0, 1'b0, 1'b0};
        v[3] = '{"bltu_t", 32'h0020E463, 1'b0, 1'b1, 1'b1, 1'b1};
        v[4] = '{"bge_nt", 32'h0020D463, 1'b0, 1'b1, 1'b0, 1'b0};
        v[5] = '{"bgeu_t", 32'h0020F463, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            inst = v[i].ins; run = 1'b1; BrEq = v[i].eq; BrLT = v[i].lt; mem_ready = 1'b1;
            tick(); tick();
            checks++; if (state !== S_EXEC || PCWEn !== 1'b1 || PCSel !== v[i].pcs) begin failures++; $display("FAIL %s_exec state=%0d pcwen=%b pcsel=%b exp state=2 pcwen=1 pcsel=%b", v[i].nm, state, PCWEn, PCSel, v[i].pcs); end
            checks++; if ({immSel, ALUsrc1, ALUsrc2, BrUn, aluSel, RegWEn, mem_req} !== {3'd2, 1'b1, 1'b1, v[i].un, 4'b0000, 1'b0, 1'b0})
                begin failures++; $display("FAIL %s_ctrl got imm=%0d s1=%b s2=%b brun=%b alu=%b regwen=%b memreq=%b exp imm=2 s1=1 s2=1 brun=%b alu=0000 regwen=0 memreq=0", v[i].nm, immSel, ALUsrc1, ALUsrc2, BrUn, aluSel, RegWEn, mem_req, v[i].un); end
            tick();
            checks++; if (state !== S_FETCH) begin failures++; $display("FAIL %s_no_wb got=%0d exp=0", v[i].nm, state); end
        end
        BrEq = 1'b0; BrLT = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_load();
        int cyc;
        // lw x5,0(x1) with two wait cycles
        inst = 32'h0000A283; run = 1'b1; mem_ready = 1'b0; cyc = 0;
        tick(); cyc++;
        tick(); cyc++;
        mem_ready = 1'b1;
        #1;
        checks++; if (state !== S_EXEC || mem_req !== 1'b0) begin failures++; $display("FAIL lw_exec state=%0d memreq=%b exp state=2 memreq=0", state, mem_req); end
        tick(); cyc++;
        for (int w = 0; w < 3; w++) begin
            mem_ready = (w == 2);
            #1;
            checks++; if ({state, mem_req, memRW, ldU, RegWEn, PCWEn} !== {S_MEM, 5'b10000})
                begin failures++; $display("FAIL lw_mem%0d got state=%0d memreq=%b memrw=%b ldu=%b regwen=%b pcwen=%b exp state=3 memreq=1 rest 0", w, state, mem_req, memRW, ldU, RegWEn, PCWEn); end
            tick(); cyc++;
        end
        mem_ready = 1'b0;
        checks++; if ({state, wb_select, RegWEn, PCWEn, PCSel, mem_req} !== {S_WB, 2'd0, 4'b1100})
            begin failures++; $display("FAIL lw_wb got state=%0d wb=%0d regwen=%b pcwen=%b pcsel=%b memreq=%b exp state=4 wb=0 regwen=1 pcwen=1 pcsel=0 memreq=0", state, wb_select, RegWEn, PCWEn, PCSel, mem_req); end
        tick(); cyc++;
        checks++; if (state !== S_FETCH || cyc != 7) begin failures++; $display("FAIL lw_latency state=%0d cycles=%0d exp state=0 cycles=7", state, cyc); end
        // lbu zero wait: unsigned load flag
        inst = 32'h0000C283; mem_ready = 1'b1;
        tick(); tick(); tick();
        checks++; if (state !== S_MEM || ldU !== 1'b1 || mem_req !== 1'b1) begin failures++; $display("FAIL lbu_mem state=%0d ldu=%b memreq=%b exp state=3 ldu=1 memreq=1", state, ldU, mem_req); end
        tick();
        checks++; if (state !== S_WB || wb_select !== 2'd0) begin failures++; $display("FAIL lbu_wb state=%0d wb=%0d exp state=4 wb=0", state, wb_select); end
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_store();
        logic sawReg;
        int cyc;
        inst = 32'h0020A223; run = 1'b1; mem_ready = 1'b1; sawReg = 1'b0; cyc = 0;
        for (int c = 0; c < 3; c++) begin
            tick(); cyc++;
            sawReg = sawReg | RegWEn;
        end
        checks++; if ({state, mem_req, memRW, immSel, PCWEn, PCSel} !== {S_MEM, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0})
            begin failures++; $display("FAIL sw_mem got state=%0d memreq=%b memrw=%b imm=%0d pcwen=%b pcsel=%b exp state=3 memreq=1 memrw=1 imm=1 pcwen=1 pcsel=0", state, mem_req, memRW, immSel, PCWEn, PCSel); end
        tick(); cyc++;
        sawReg = sawReg | RegWEn;
        checks++; if (state !== S_FETCH || cyc != 4) begin failures++; $display("FAIL sw_latency state=%0d cycles=%0d exp state=0 cycles=4", state, cyc); end
        checks++; if (sawReg !== 1'b0) begin failures++; $display("FAIL sw_regwen got=%b exp=0", sawReg); end
        mem_ready = 1'b0;
    endtask

    task automatic test_trap();
        inst = 32'h00000000; run = 1'b1;
        tick();
        checks++; if (state !== S_DECODE) begin failures++; $display("FAIL trap_decode got=%0d exp=1", state); end
        for (int c = 0; c < 10; c++) begin
            tick();
            mem_ready = c[0];
            #1;
            checks++; if ({state, illegal, PCWEn, RegWEn, mem_req} !== {S_TRAP, 4'b1000})
                begin failures++; $display("FAIL trap_hold%0d got state=%0d illegal=%b pcwen=%b regwen=%b memreq=%b exp state=5 illegal=1 rest 0", c, state, illegal, PCWEn, RegWEn, mem_req); end
        end
        reset = 1'b0; run = 1'b0; mem_ready = 1'b0;
        tick();
        checks++; if (state !== S_FETCH || illegal !== 1'b0) begin failures++; $display("FAIL trap_clear state=%0d illegal=%b exp state=0 illegal=0", state, illegal); end
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_mem();
        logic sawReg;
        inst = 32'h0000A283; run = 1'b1; mem_ready = 1'b0; sawReg = 1'b0;
        tick(); tick(); tick();
        checks++; if (state !== S_MEM || mem_req !== 1'b1) begin failures++; $display("FAIL rmm_in_mem state=%0d memreq=%b exp state=3 memreq=1", state, mem_req); end
        reset = 1'b0;
        tick();
        sawReg = sawReg | RegWEn;
        checks++; if (state !== S_FETCH || mem_req !== 1'b0) begin failures++; $display("FAIL rmm_abort state=%0d memreq=%b exp state=0 memreq=0", state, mem_req); end
        reset = 1'b1; run = 1'b0; mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            sawReg = sawReg | RegWEn;
        end
        checks++; if (state !== S_FETCH || sawReg !== 1'b0) begin failures++; $display("FAIL rmm_no_wb state=%0d regwen_seen=%b exp state=0 regwen_seen=0", state, sawReg); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_load();
        test_store();
        test_trap();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
